// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU micro-program sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE
    } seqState_t;

    // Instruction word layout at the default 8-bit data width: {halt, op, data}
    localparam int OP_W     = 4;
    localparam int HALT_BIT = 12;
    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    // ALU opcodes, passed through to the ALU unchanged
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SHL   = 4'd2;
    localparam logic [3:0] OP_SHR   = 4'd3;
    localparam logic [3:0] OP_CMP   = 4'd4;
    localparam logic [3:0] OP_LAND  = 4'd5;
    localparam logic [3:0] OP_LOR   = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NAND  = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_XNOR  = 4'd10;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_NEG   = 4'd12;
    localparam logic [3:0] OP_MOVYA = 4'd13;
    localparam logic [3:0] OP_SWAP  = 4'd14;
    localparam logic [3:0] OP_LOADA = 4'd15;

    // Builds a default-width instruction word
    function automatic logic [HALT_BIT:0] packWord(input logic halt,
                                                   input logic [OP_W-1:0] op,
                                                   input logic [DATA_MSB:0] data);
        return {halt, op, data};
    endfunction

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store: one write port, registered read port, contents not reset.
module alu_seq_prog_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WORD_W = HALT_BIT + 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WORD_W-1:0] i_wrData,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WORD_W-1:0] o_rdData
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write a word when enabled; read word appears one cycle after the read enable
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_re) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Steps through the program memory and drives the ALU with a
// setup / one-cycle doAction pulse / gap sequence per instruction.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int STEP_GAP   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W+4:0] prog_word,
    input  logic              start,
    input  logic              clr_on_start,
    input  logic              abort,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_data,
    output logic              alu_do,
    output logic              alu_reset,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              wr_rej,
    output logic [ADDR_W-1:0] pc
);

    localparam int WordW   = DATA_W + OP_W + 1;
    localparam int HaltPos = DATA_W + OP_W;
    localparam int GapW    = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [GapW-1:0]   GapLoad  = GapW'(STEP_GAP - 1);

    seqState_t         r_state;
    seqState_t         w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [GapW-1:0]   r_gapCnt;
    logic              r_halt;
    logic [OP_W-1:0]   r_aluOp;
    logic [DATA_W-1:0] r_aluData;
    logic              r_aborted;
    logic              r_wrRej;
    logic [WordW-1:0]  w_rdWord;
    logic              w_isIdle;
    logic              w_memWe;
    logic              w_memRe;
    logic              w_gapEnd;
    logic              w_lastInstr;
    logic              w_advance;

    assign w_isIdle    = (r_state == S_IDLE);
    assign w_memWe     = prog_we && w_isIdle;
    assign w_memRe     = (r_state == S_FETCH);
    assign w_gapEnd    = (r_gapCnt == '0);
    assign w_lastInstr = r_halt || (r_pc == LastAddr);
    assign w_advance   = (r_state == S_GAP) && w_gapEnd && !w_lastInstr && !abort;

    alu_seq_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WordW)
    ) u_progMem (
        .clk      (clk),
        .i_we     (w_memWe),
        .i_wrAddr (prog_addr),
        .i_wrData (prog_word),
        .i_re     (w_memRe),
        .i_rdAddr (r_pc),
        .o_rdData (w_rdWord)
    );

    // During SETUP the freshly read word is shown directly so op/data lead the pulse by a cycle
    assign alu_op   = (r_state == S_SETUP) ? w_rdWord[DATA_W +: OP_W] : r_aluOp;
    assign alu_data = (r_state == S_SETUP) ? w_rdWord[DATA_W-1:0]     : r_aluData;
    assign aborted  = r_aborted;
    assign wr_rej   = r_wrRej;
    assign pc       = r_pc;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and strobe decode; abort overrides everything outside IDLE
    always_comb begin
        w_nextState = r_state;
        alu_do      = 1'b0;
        alu_reset   = 1'b0;
        busy        = !w_isIdle;
        done        = 1'b0;
        case (r_state)
            S_CLEAR: alu_reset = 1'b1;
            S_PULSE: alu_do    = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
        if (!w_isIdle && abort) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_nextState = clr_on_start ? S_CLEAR : S_FETCH;
                S_CLEAR: w_nextState = S_FETCH;
                S_FETCH: w_nextState = S_SETUP;
                S_SETUP: w_nextState = S_PULSE;
                S_PULSE: w_nextState = S_GAP;
                S_GAP:   if (w_gapEnd) w_nextState = w_lastInstr ? S_DONE : S_FETCH;
                S_DONE:  w_nextState = S_IDLE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Program counter, gap timer, latched instruction fields and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= '0;
            r_gapCnt  <= '0;
            r_halt    <= 1'b0;
            r_aluOp   <= '0;
            r_aluData <= '0;
            r_aborted <= 1'b0;
            r_wrRej   <= 1'b0;
        end else begin
            r_aborted <= abort && !w_isIdle;
            r_wrRej   <= prog_we && !w_isIdle;
            if (w_isIdle && start) begin
                r_pc <= '0;
            end else if (w_advance) begin
                r_pc <= r_pc + 1'b1;
            end
            if (r_state == S_PULSE) begin
                r_gapCnt <= GapLoad;
            end else if (r_state == S_GAP && !w_gapEnd) begin
                r_gapCnt <= r_gapCnt - 1'b1;
            end
            if (r_state == S_SETUP) begin
                r_halt    <= w_rdWord[HaltPos];
                r_aluOp   <= w_rdWord[DATA_W +: OP_W];
                r_aluData <= w_rdWord[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on the main instance.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, prog_we, start, clrOnStart, abort, start3;
    logic [3:0]  prog_addr;
    logic [12:0] prog_word;

    logic [3:0]  d1Op, d1Pc, d3Op, d3Pc;
    logic [7:0]  d1Data, d3Data;
    logic        d1Do, d1Rst, d1Busy, d1Done, d1Aborted, d1WrRej;
    logic        d3Do, d3Rst, d3Busy, d3Done, d3Aborted, d3WrRej;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic       aluDo;
        logic       aluRst;
        logic       busy;
        logic       done;
        logic [3:0] pc;
        logic [3:0] op;
        logic [7:0] data;
    } obs_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [12:0] word;
    } progRow_t;

    obs_t     expTab [19];
    obs_t     actObs;
    progRow_t prog [4];

    int doCnt1 = 0, doCnt3 = 0, rstCnt1 = 0, doneCnt1 = 0, abortCnt1 = 0;
    int overlapCnt = 0, longPulseCnt = 0;
    logic prevDo1 = 1'b0, prevDo3 = 1'b0;
    int base1, base3, rstBase, doneBase, abBase, np, doneAt, ins, ph;
    int pulseAt [4];
    bit stable [4];
    bit wrapSeen, idleOk;
    logic [3:0] prevPc;
    logic [7:0] aluA, aluB, aluY;

    always #5 clk = ~clk;

    alu_sequencer #(.PROG_DEPTH(16), .ADDR_W(4), .DATA_W(8), .STEP_GAP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_word(prog_word), .start(start), .clr_on_start(clrOnStart), .abort(abort),
        .alu_op(d1Op), .alu_data(d1Data), .alu_do(d1Do), .alu_reset(d1Rst),
        .busy(d1Busy), .done(d1Done), .aborted(d1Aborted), .wr_rej(d1WrRej), .pc(d1Pc)
    );

    alu_sequencer #(.PROG_DEPTH(16), .ADDR_W(4), .DATA_W(8), .STEP_GAP(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_word(prog_word), .start(start3), .clr_on_start(1'b0), .abort(1'b0),
        .alu_op(d3Op), .alu_data(d3Data), .alu_do(d3Do), .alu_reset(d3Rst),
        .busy(d3Busy), .done(d3Done), .aborted(d3Aborted), .wr_rej(d3WrRej), .pc(d3Pc)
    );

    // Behavioural ALU for the ops used by the test program, acting on doAction rising edges
    always @(posedge d1Do or posedge d1Rst) begin
        if (d1Rst) begin
            aluA <= 8'h00;
            aluB <= 8'h00;
            aluY <= 8'h00;
        end else begin
            case (d1Op)
                OP_LOADA: aluA <= d1Data;
                OP_ADD:   aluY <= aluA + aluB;
                OP_MOVYA: aluA <= aluY;
                OP_SHL:   aluY <= aluA << 1;
                default:  ;
            endcase
        end
    end

    // Strobe monitor sampled on the falling edge
    always @(negedge clk) begin
        if (d1Do) doCnt1++;
        if (d3Do) doCnt3++;
        if (d1Do && prevDo1) longPulseCnt++;
        if (d3Do && prevDo3) longPulseCnt++;
        if (d1Do && d1Rst) overlapCnt++;
        if (d3Do && d3Rst) overlapCnt++;
        if (d1Rst) rstCnt1++;
        if (d1Done) doneCnt1++;
        if (d1Aborted) abortCnt1++;
        prevDo1 = d1Do;
        prevDo3 = d3Do;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs at a falling edge and returns at the next falling edge
    task automatic applyStimulus(input logic st = 1'b0, input logic clr = 1'b0,
                                 input logic ab = 1'b0, input logic we = 1'b0,
                                 input logic [3:0] addr = 4'd0, input logic [12:0] word = 13'd0);
        start      = st;
        clrOnStart = clr;
        abort      = ab;
        prog_we    = we;
        prog_addr  = addr;
        prog_word  = word;
        @(negedge clk);
    endtask

    task automatic loadProg();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, prog[i].addr, prog[i].word);
        end
    endtask

    initial begin
        reset_n = 1'b0; prog_we = 1'b0; start = 1'b0; clrOnStart = 1'b0;
        abort = 1'b0; start3 = 1'b0; prog_addr = 4'd0; prog_word = 13'd0;

        prog[0] = '{4'd0, packWord(1'b0, OP_LOADA, 8'h05)};
        prog[1] = '{4'd1, packWord(1'b0, OP_ADD,   8'h00)};
        prog[2] = '{4'd2, packWord(1'b0, OP_MOVYA, 8'h00)};
        prog[3] = '{4'd3, packWord(1'b1, OP_SHL,   8'h00)};

        //                 do   rst  busy done pc     op     data
        expTab[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0,  8'h00};
        expTab[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  8'h00};
        expTab[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 8'h05};
        expTab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 8'h05};
        expTab[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 8'h05};
        expTab[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd15, 8'h05};
        expTab[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0,  8'h00};
        expTab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0,  8'h00};
        expTab[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0,  8'h00};
        expTab[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0,  8'h00};
        expTab[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd13, 8'h00};
        expTab[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd13, 8'h00};
        expTab[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd13, 8'h00};
        expTab[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd13, 8'h00};
        expTab[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2,  8'h00};
        expTab[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2,  8'h00};
        expTab[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd2,  8'h00};
        expTab[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd2,  8'h00};
        expTab[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2,  8'h00};

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {d1Op, d1Data, d1Do, d1Rst, d1Busy, d1Done, d1Aborted, d1WrRej, d1Pc}, 32'd0);
        checkOutput("reset_outputs_gap3", {d3Busy, d3Do, d3Pc}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Program with clear, cycle-by-cycle against the table
        loadProg();
        base1 = doCnt1; rstBase = rstCnt1;
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 19; i++) begin
            actObs = '{d1Do, d1Rst, d1Busy, d1Done, d1Pc, d1Op, d1Data};
            checkOutput($sformatf("t1_cycle%0d", i + 1), 32'(actObs), 32'(expTab[i]));
            applyStimulus();
        end
        checkOutput("t1_pulse_count", doCnt1 - base1, 32'd4);
        checkOutput("t1_clear_count", rstCnt1 - rstBase, 32'd1);
        checkOutput("t1_alu_y", aluY, 32'h0A);
        checkOutput("t1_alu_a", aluA, 32'h05);

        // Same program on the STEP_GAP=3 instance, no clear
        np = 0; doneAt = -1;
        for (int i = 0; i < 4; i++) stable[i] = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            if (d3Do) begin
                if (np < 4) pulseAt[np] = k;
                np++;
            end
            if (d3Done) doneAt = k;
            if (k >= 2 && k <= 24) begin
                ins = (k - 2) / 6;
                ph  = (k - 2) % 6;
                if (ph <= 4 && {d3Op, d3Data} !== prog[ins].word[11:0]) stable[ins] = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("t2_pulse_count", np, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_pulse%0d_cycle", i), pulseAt[i], 32'(3 + 6 * i));
            checkOutput($sformatf("t2_stable%0d", i), 32'(stable[i]), 32'd1);
        end
        checkOutput("t2_done_cycle", doneAt, 32'd25);

        // Full memory without halt: last word terminates, pc never wraps
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'(a), packWord(1'b0, OP_LOADA, 8'h11));
        end
        base1 = doCnt1; doneBase = doneCnt1; prevPc = 4'd0; wrapSeen = 1'b0; doneAt = -1;
        applyStimulus(1'b1);
        for (int k = 1; k <= 70; k++) begin
            if (d1Busy && d1Pc < prevPc) wrapSeen = 1'b1;
            if (d1Busy) prevPc = d1Pc;
            if (d1Done && doneAt < 0) doneAt = k;
            applyStimulus();
        end
        checkOutput("t3_pulse_count", doCnt1 - base1, 32'd16);
        checkOutput("t3_final_pc", d1Pc, 32'd15);
        checkOutput("t3_no_wrap", 32'(wrapSeen), 32'd0);
        checkOutput("t3_done_count", doneCnt1 - doneBase, 32'd1);
        checkOutput("t3_done_cycle", doneAt, 32'd65);

        // Abort during the gap of instruction 2, then restart
        loadProg();
        base1 = doCnt1; doneBase = doneCnt1; abBase = abortCnt1;
        applyStimulus(1'b1);
        repeat (11) applyStimulus();
        checkOutput("t4_in_gap_pc2", {d1Busy, d1Do, d1Pc}, {1'b1, 1'b0, 4'd2});
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4_abort_flags", {d1Aborted, d1Busy, d1Do, d1Done}, 32'b1000);
        repeat (10) applyStimulus();
        checkOutput("t4_pulse_count", doCnt1 - base1, 32'd3);
        checkOutput("t4_no_done", doneCnt1 - doneBase, 32'd0);
        checkOutput("t4_aborted_count", abortCnt1 - abBase, 32'd1);
        applyStimulus(1'b1);
        checkOutput("t4_restart_pc0", {d1Busy, d1Pc}, {1'b1, 4'd0});
        repeat (20) applyStimulus();
        checkOutput("t4_restart_done", doneCnt1 - doneBase, 32'd1);

        // Write and start while busy are both dropped
        base1 = doCnt1; doneBase = doneCnt1;
        applyStimulus(1'b1);
        repeat (4) applyStimulus();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, packWord(1'b1, OP_LOADA, 8'h77));
        checkOutput("t5_wr_rej", d1WrRej, 32'd1);
        applyStimulus(1'b1);
        checkOutput("t5_wr_rej_one_cycle", d1WrRej, 32'd0);
        repeat (14) applyStimulus();
        checkOutput("t5_pulse_count", doCnt1 - base1, 32'd4);
        checkOutput("t5_done_count", doneCnt1 - doneBase, 32'd1);
        applyStimulus(1'b1);
        repeat (14) applyStimulus();
        checkOutput("t5_mem3_unchanged", {d1Do, d1Op, d1Data}, {1'b1, OP_SHL, 8'h00});
        repeat (5) applyStimulus();

        // Asynchronous reset in the middle of a pulse
        applyStimulus(1'b1);
        repeat (6) applyStimulus();
        checkOutput("t6_in_pulse_pc1", {d1Do, d1Pc}, {1'b1, 4'd1});
        #2 reset_n = 1'b0;
        #1 checkOutput("t6_async_drop", {d1Do, d1Busy, d1Pc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idleOk = 1'b1;
        repeat (5) begin
            applyStimulus();
            if (d1Busy || d1Do) idleOk = 1'b0;
        end
        checkOutput("t6_idle_holds", 32'(idleOk), 32'd1);

        checkOutput("do_reset_overlap", overlapCnt, 32'd0);
        checkOutput("pulse_width", longPulseCnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
